// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the ADC SPI capture engine.
package adc_capture_pkg;

  localparam int ADC_BITS_DEF   = 12;
  localparam int FRAME_BITS_DEF = 16;

  // Capture FSM states; exported on dbg_state so checkers can bind to it.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    PUSH  = 3'd3,
    QUIET = 3'd4,
    FIN   = 3'd5
  } state_t;

  // Larger of two ints, used to size the shared phase timer.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous show-ahead pixel FIFO with full/empty flags.
// The head entry is visible on pop_data whenever empty is low. A pop on an
// empty FIFO is ignored. A push on a full FIFO is accepted only if a pop
// frees a slot in the same cycle; otherwise it is dropped and the caller
// is responsible for flagging the loss.
module capture_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         pop_ok;
  logic         push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head is forced to zero when empty so the output is defined out of reset.
  assign pop_data = empty ? '0 : mem[rd_q[AW-1:0]];

  // Storage write; no reset needed since empty gates the read side.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_q[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + (AW+1)'(1);
      if (pop_ok)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/adc_spi_capture.sv
// ADC SPI capture engine: drives an ADCS7476-class serial ADC over
// cs/SPI_CLK/miso for num_pixels conversions and buffers the pixels in a
// show-ahead FIFO offered downstream on pix_valid/pix_ready.
// Optional build macro CAPTURE_TESTPATTERN_EN: pixels become a per-capture
// 0,1,2,... counter instead of miso data (SPI timing is still generated).
//
// Handshake: pix_valid is high whenever the FIFO holds a pixel and pix_data
// is that pixel; a pixel is consumed on a CLK edge where pix_valid and
// pix_ready are both high. pix_valid never depends on pix_ready.
module adc_spi_capture
  import adc_capture_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int ADC_BITS   = ADC_BITS_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int QUIET_CYC  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                start,
  input  logic [15:0]         num_pixels,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                cs,
  output logic                SPI_CLK,
  input  logic                miso,
  output logic [ADC_BITS-1:0] pix_data,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                startCaptureTP,
  output state_t              dbg_state
);

  localparam int TMR_MAX = max2(CLK_DIV, QUIET_CYC);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS);

  localparam logic [TMR_W-1:0] DIV_LAST   = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] QUIET_LAST = TMR_W'(QUIET_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                sclk_q, sclk_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ADC_BITS-1:0] shift_q, shift_d;
  logic                cs_q, busy_q, done_q, tp_q, ovf_q;

  logic                start_acc;
  logic                fifo_push;
  logic [ADC_BITS-1:0] fifo_wdata;
  logic                fifo_full;
  logic                fifo_empty;

  // A start is only honoured from IDLE; anything else is dropped silently.
  assign start_acc = start && (state_q == IDLE);

  assign cs             = cs_q;
  assign SPI_CLK        = sclk_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow       = ovf_q;
  assign startCaptureTP = tp_q;
  assign pix_valid      = !fifo_empty;
  assign dbg_state      = state_q;

`ifdef CAPTURE_TESTPATTERN_EN
  logic [ADC_BITS-1:0] pat_q;

  // Test pattern counter: restarts on each accepted start, steps per PUSH.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pat_q <= '0;
    end else if (start_acc) begin
      pat_q <= '0;
    end else if (state_q == PUSH) begin
      pat_q <= pat_q + ADC_BITS'(1);
    end
  end

  assign fifo_wdata = pat_q;
`else
  assign fifo_wdata = shift_q;
`endif

  // State and datapath registers; reset parks the SPI lines idle at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b1;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Next-state and SPI timing: one timer paces SETUP, each SCLK half and QUIET.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_d     = bit_q;
    sclk_d    = sclk_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    fifo_push = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = 1'b1;
        tmr_d  = '0;
        bit_d  = '0;
        if (start) begin
          cnt_d   = num_pixels;
          state_d = (num_pixels != 16'd0) ? SETUP : FIN;
        end
      end
      SETUP: begin
        sclk_d = 1'b1;
        if (tmr_q == DIV_LAST) begin
          tmr_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      SHIFT: begin
        if (tmr_q == DIV_LAST) begin
          tmr_d = '0;
          if (!sclk_q) begin
            // Rising SCLK edge: capture the bit the ADC set up on the fall.
            sclk_d  = 1'b1;
            shift_d = {shift_q[ADC_BITS-2:0], miso};
          end else if (bit_q == BIT_LAST) begin
            state_d = PUSH;
          end else begin
            bit_d  = bit_q + BIT_W'(1);
            sclk_d = 1'b0;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      PUSH: begin
        fifo_push = 1'b1;
        tmr_d     = '0;
        cnt_d     = cnt_q - 16'd1;
        state_d   = (cnt_q == 16'd1) ? FIN : QUIET;
      end
      QUIET: begin
        if (tmr_q == QUIET_LAST) begin
          tmr_d   = '0;
          state_d = SETUP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs registered from the next state so they track it glitch-free.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cs_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tp_q   <= 1'b0;
    end else begin
      cs_q   <= !((state_d == SETUP) || (state_d == SHIFT));
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == FIN);
      tp_q   <= start_acc;
    end
  end

  // Sticky overflow: a PUSH onto a full FIFO with no same-cycle pop loses data.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ovf_q <= 1'b0;
    end else if (start_acc) begin
      ovf_q <= 1'b0;
    end else if (fifo_push && fifo_full && !pix_ready) begin
      ovf_q <= 1'b1;
    end
  end

  capture_fifo #(
    .W     (ADC_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (pix_ready),
    .pop_data  (pix_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_adc_spi_capture.sv
// Self-checking bench for adc_spi_capture (default parameters).
// Honours CAPTURE_TESTPATTERN_EN when the design is built with it.
`timescale 1ns/1ps
module tb_adc_spi_capture;
  import adc_capture_pkg::*;

  localparam int ADC_BITS   = 12;
  localparam int FRAME_BITS = 16;
  localparam int QUIET_CYC  = 8;

  // ---------------- clock / reset ----------------
  logic                CLK = 1'b0;
  logic                RESET = 1'b1;
  logic                start = 1'b0;
  logic [15:0]         num_pixels = '0;
  logic                miso = 1'b0;
  logic                pix_ready = 1'b0;
  logic                busy, done, overflow, cs, SPI_CLK, pix_valid, startCaptureTP;
  logic [ADC_BITS-1:0] pix_data;
  state_t              dbg_state;

  always #5 CLK = ~CLK;

  adc_spi_capture dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .start          (start),
    .num_pixels     (num_pixels),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .cs             (cs),
    .SPI_CLK        (SPI_CLK),
    .miso           (miso),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .startCaptureTP (startCaptureTP),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int                  n_vec = 0;
  int                  n_err = 0;
  logic [ADC_BITS-1:0] exp_q[$];
  logic [15:0]         adc_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [ADC_BITS-1:0] exp_pix(input logic [11:0] d, input int idx);
`ifdef CAPTURE_TESTPATTERN_EN
    exp_pix = ADC_BITS'(idx);
`else
    exp_pix = d;
`endif
  endfunction

  // Queue one ADC frame (4 leading zeros + 12 data bits); optionally expect it.
  task automatic add_frame(input logic [11:0] d, input int idx, input bit store);
    adc_q.push_back({4'h0, d});
    if (store) exp_q.push_back(exp_pix(d, idx));
  endtask

  // Popped pixels compared against the expected queue.
  initial forever begin
    @(negedge CLK);
    if (!RESET && pix_valid && pix_ready) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL pix_extra: observed %0h expected none", pix_data);
      end
      if (exp_q.size() != 0) check("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- ADC model ----------------
  // Loads a frame when cs falls and presents the next bit MSB first on each
  // falling SCLK edge, so the DUT samples it on the following rising edge.
  logic [15:0] cur_frame = '0;
  int          bit_idx = 0;
  bit          in_frame = 0;
  logic        sclk_last = 1'b1;

  initial forever begin
    @(cs or SPI_CLK);
    if (cs !== 1'b0) begin
      in_frame = 0;
    end else if (!in_frame) begin
      in_frame  = 1;
      cur_frame = (adc_q.size() != 0) ? adc_q.pop_front() : 16'(($urandom_range(0, 4095)));
      bit_idx   = 15;
    end else if (SPI_CLK === 1'b0 && sclk_last === 1'b1 && bit_idx >= 0) begin
      miso    = cur_frame[bit_idx];
      bit_idx = bit_idx - 1;
    end
    sclk_last = SPI_CLK;
  end

  // ---------------- timing / event monitor ----------------
  int   cyc = 0;
  int   done_cnt, tp_cnt, cs_falls, frames, bad_frames, rises;
  int   last_rise, min_per, max_per, cs_rise_cyc, min_cs_high;
  logic cs_prev = 1'b1;
  logic sclk_prev = 1'b1;

  task automatic clear_stats();
    done_cnt = 0; tp_cnt = 0; cs_falls = 0; frames = 0; bad_frames = 0; rises = 0;
    last_rise = -1; min_per = 9999; max_per = 0; cs_rise_cyc = -1; min_cs_high = 9999;
  endtask

  initial forever begin
    @(negedge CLK);
    cyc++;
    if (done) done_cnt++;
    if (startCaptureTP) tp_cnt++;
    if (cs_prev && !cs) begin
      cs_falls++;
      if (cs_rise_cyc >= 0 && (cyc - cs_rise_cyc) < min_cs_high) min_cs_high = cyc - cs_rise_cyc;
      rises = 0;
      last_rise = -1;
    end
    if (!cs && !sclk_prev && SPI_CLK) begin
      rises++;
      if (last_rise >= 0) begin
        if (cyc - last_rise < min_per) min_per = cyc - last_rise;
        if (cyc - last_rise > max_per) max_per = cyc - last_rise;
      end
      last_rise = cyc;
    end
    if (!cs_prev && cs) begin
      frames++;
      if (rises != FRAME_BITS) bad_frames++;
      cs_rise_cyc = cyc;
    end
    cs_prev   = cs;
    sclk_prev = SPI_CLK;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start      = 1'b1;
    num_pixels = n;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k = 0;
    while (done !== 1'b1 && k < bound) begin
      @(negedge CLK);
      k++;
    end
    check(tag, 32'(done), 32'(1));
    tick();
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      tick();
      k++;
    end
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic wait_frames(input int n, input int bound);
    int k = 0;
    while (frames < n && k < bound) begin
      @(negedge CLK);
      k++;
    end
    check("frames_reached", 32'(frames >= n), 32'(1));
  endtask

  task automatic wait_state(input state_t s, input bit need_low_sclk, input int bound);
    int k = 0;
    @(negedge CLK);
    while (!(dbg_state == s && (!need_low_sclk || SPI_CLK == 1'b0)) && k < bound) begin
      @(negedge CLK);
      k++;
    end
    check("state_reached", 32'(dbg_state), 32'(s));
  endtask

  // Global time limit so the run always ends.
  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    clear_stats();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_cs", 32'(cs), 32'(1));
    check("rst_sclk", 32'(SPI_CLK), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ovf", 32'(overflow), 32'(0));
    check("rst_valid", 32'(pix_valid), 32'(0));
    check("rst_data", 32'(pix_data), 32'(0));
    check("rst_tp", 32'(startCaptureTP), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    RESET = 1'b0;
    tick();

    // Three known conversions with continuous draining, plus SPI timing.
    pix_ready = 1'b1;
    clear_stats();
    add_frame(12'hABC, 0, 1);
    add_frame(12'h123, 1, 1);
    add_frame(12'hFFF, 2, 1);
    check("t1_busy_pre", 32'(busy), 32'(0));
    do_start(16'd3);
    check("t1_busy_rise", 32'(busy), 32'(1));
    check("t1_cs_fall", 32'(cs), 32'(0));
    check("t1_tp", 32'(startCaptureTP), 32'(1));
    check("t1_state", 32'(dbg_state), 32'(SETUP));
    tick();
    check("t1_tp_clear", 32'(startCaptureTP), 32'(0));
    wait_done("t1_done", 2000);
    check("t1_busy_fall", 32'(busy), 32'(0));
    wait_drain("t1_drain", 50);
    check("t1_done_cnt", 32'(done_cnt), 32'(1));
    check("t1_cs_lows", 32'(cs_falls), 32'(3));
    check("t1_frames", 32'(frames), 32'(3));
    check("t2_rises_per_frame", 32'(bad_frames), 32'(0));
    check("t2_period_min", 32'(min_per), 32'(8));
    check("t2_period_max", 32'(max_per), 32'(8));
    check("t2_cs_quiet", 32'(min_cs_high >= QUIET_CYC), 32'(1));

    // Overflow: 20 conversions into a 16-deep FIFO with no draining.
    pix_ready = 1'b0;
    clear_stats();
    for (int i = 0; i < 20; i++) add_frame(12'($urandom_range(0, 4095)), i, i < 16);
    do_start(16'd20);
    wait_frames(16, 3000);
    repeat (3) tick();
    check("t3_ovf_at16", 32'(overflow), 32'(0));
    check("t3_valid", 32'(pix_valid), 32'(1));
    wait_frames(17, 300);
    repeat (3) tick();
    check("t3_ovf_at17", 32'(overflow), 32'(1));
    wait_done("t3_done", 1000);
    check("t3_ovf_sticky", 32'(overflow), 32'(1));

    // New start clears overflow; push and pop in the same cycle on a full FIFO.
    add_frame(12'($urandom_range(0, 4095)), 0, 1);
    do_start(16'd1);
    check("t3_ovf_clear", 32'(overflow), 32'(0));
    wait_state(PUSH, 0, 400);
    #1;
    pix_ready = 1'b1;
    check("t3_pop_on_full", 32'(pix_data), 32'(exp_q.pop_front()));
    tick();
    pix_ready = 1'b0;
    check("t3_no_ovf_pushpop", 32'(overflow), 32'(0));
    wait_done("t3b_done", 100);
    pix_ready = 1'b1;
    wait_drain("t3_drain", 100);
    tick();
    check("t3_empty", 32'(pix_valid), 32'(0));

    // num_pixels=0 with pixels held in the FIFO; FIFO is neither touched nor flushed.
    pix_ready = 1'b0;
    add_frame(12'($urandom_range(0, 4095)), 0, 1);
    add_frame(12'($urandom_range(0, 4095)), 1, 1);
    do_start(16'd2);
    wait_done("t4_fill_done", 1000);
    clear_stats();
    do_start(16'd0);
    check("t4_done", 32'(done), 32'(1));
    check("t4_busy", 32'(busy), 32'(1));
    check("t4_cs", 32'(cs), 32'(1));
    check("t4_state", 32'(dbg_state), 32'(FIN));
    tick();
    check("t4_done_end", 32'(done), 32'(0));
    check("t4_busy_end", 32'(busy), 32'(0));
    check("t4_cs_never", 32'(cs_falls), 32'(0));
    check("t4_fifo_kept", 32'(pix_valid), 32'(1));
    add_frame(12'($urandom_range(0, 4095)), 0, 1);
    add_frame(12'($urandom_range(0, 4095)), 1, 1);
    do_start(16'd2);
    wait_done("t4_more_done", 1000);
    pix_ready = 1'b1;
    wait_drain("t4_drain", 50);
    check("t4_done_cnt", 32'(done_cnt), 32'(2));

    // Starts while busy are ignored.
    clear_stats();
    add_frame(12'($urandom_range(0, 4095)), 0, 1);
    add_frame(12'($urandom_range(0, 4095)), 1, 1);
    do_start(16'd2);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(5, 60)) tick();
      do_start(16'd7);
    end
    wait_done("t5_done", 1000);
    wait_drain("t5_drain", 50);
    check("t5_tp_once", 32'(tp_cnt), 32'(1));
    check("t5_done_once", 32'(done_cnt), 32'(1));
    check("t5_cs_lows", 32'(cs_falls), 32'(2));

    // Asynchronous reset in the middle of a conversion.
    add_frame(12'($urandom_range(0, 4095)), 0, 0);
    do_start(16'd1);
    wait_state(SHIFT, 1, 400);
    #2;
    RESET = 1'b1;
    #1;
    check("t5_rst_cs", 32'(cs), 32'(1));
    check("t5_rst_sclk", 32'(SPI_CLK), 32'(1));
    check("t5_rst_busy", 32'(busy), 32'(0));
    check("t5_rst_state", 32'(dbg_state), 32'(IDLE));
    check("t5_rst_valid", 32'(pix_valid), 32'(0));
    adc_q.delete();
    @(negedge CLK);
    RESET = 1'b0;
    tick();

    // Five conversions with random data (counter values in test-pattern builds).
    for (int i = 0; i < 5; i++) add_frame(12'($urandom_range(0, 4095)), i, 1);
    do_start(16'd5);
    wait_done("t6_done", 1500);
    wait_drain("t6_drain", 50);
    tick();
    check("t6_empty", 32'(pix_valid), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
